packet_event_monitor: RTL

//  Multi-channel successor to the single packet_detected LED/trigger stretcher in the receiver top level.
//  - Takes NUM_CH asynchronous packet-detect flags, one per Packet_Sniffer instance (e.g. advertising ch 37/38/39).
//  - Per channel: synchronises the flag, edge-detects it and stretches each event into an LED pulse and a scope-trigger pulse.
//  - Adds per-channel saturating event counters, a counter readout mux, and most-recent-channel reporting.

---
 rtl/packet_event_monitor_pkg.sv | 20 ++
 rtl/packet_event_monitor_evt_stretch_ch.sv | 104 ++++++++++
 rtl/packet_event_monitor.sv | 87 ++++++++
 3 files changed

// File: rtl/packet_event_monitor_pkg.sv
// Shared constants and types for the packet event monitor: default hold times,
// channel limits and the per-timer state encoding.
package packet_event_monitor_pkg;

    localparam int MAX_CH        = 8;
    localparam int CH_IDX_W      = $clog2(MAX_CH);
    localparam int LED_HOLD_16M  = 25_000_000;
    localparam int TRIG_HOLD_16M = 250_000;

    typedef enum logic {
        TMR_IDLE   = 1'b0,
        TMR_ACTIVE = 1'b1
    } tmr_state_e;

    // Counter width able to hold the value HOLD itself.
    function automatic int hold_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/packet_event_monitor_evt_stretch_ch.sv
// One detect channel: synchroniser, rising-edge detect, LED and trigger pulse
// stretchers, and a saturating event counter.
//
//   state      | meaning
//   TMR_IDLE   | timer count 0, pulse output low
//   TMR_ACTIVE | timer counting down from HOLD, pulse output high
module packet_event_monitor_evt_stretch_ch
    import packet_event_monitor_pkg::*;
#(
    parameter int LED_HOLD    = LED_HOLD_16M,
    parameter int TRIG_HOLD   = TRIG_HOLD_16M,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIG      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             evt_i,
    input  logic             clr_cnt_i,
    output logic             led_o,
    output logic             trig_o,
    output logic             rise_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int HOLD_MAX = (LED_HOLD > TRIG_HOLD) ? LED_HOLD : TRIG_HOLD;
    localparam int TW       = hold_width(HOLD_MAX);
    localparam logic [TW-1:0]    HOLD_V [2] = '{TW'(LED_HOLD), TW'(TRIG_HOLD)};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    tmr_state_e             state_q [2];
    tmr_state_e             state_d [2];
    logic [TW-1:0]          tmr_q   [2];
    logic [TW-1:0]          tmr_d   [2];
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q & en_i;
    assign led_o  = (state_q[0] == TMR_ACTIVE);
    assign trig_o = (state_q[1] == TMR_ACTIVE);
    assign cnt_o  = cnt_q;

    // Index 0 is the LED timer, index 1 the trigger timer.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            state_d[t] = state_q[t];
            tmr_d[t]   = tmr_q[t];
            case (state_q[t])
                TMR_IDLE: begin
                    if (rise_o) begin
                        state_d[t] = TMR_ACTIVE;
                        tmr_d[t]   = HOLD_V[t];
                    end
                end
                TMR_ACTIVE: begin
                    if (rise_o && (RETRIG != 0)) begin
                        tmr_d[t] = HOLD_V[t];
                    end else if (tmr_q[t] == TW'(1)) begin
                        state_d[t] = TMR_IDLE;
                        tmr_d[t]   = '0;
                    end else begin
                        tmr_d[t] = tmr_q[t] - TW'(1);
                    end
                end
                default: begin
                    state_d[t] = TMR_IDLE;
                    tmr_d[t]   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (rise_o && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= TMR_IDLE;
                tmr_q[t]   <= '0;
            end
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= cnt_d;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= state_d[t];
                tmr_q[t]   <= tmr_d[t];
            end
        end
    end

endmodule

// File: rtl/packet_event_monitor.sv
// Multi-channel packet-detect monitor: per-channel stretchers plus counter
// readout, most-recent-channel reporting and a combined event strobe.
module packet_event_monitor
    import packet_event_monitor_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int LED_HOLD    = LED_HOLD_16M,
    parameter int TRIG_HOLD   = TRIG_HOLD_16M,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIG      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_CH-1:0]   evt_in,
    input  logic                clr_cnt,
    input  logic [CH_IDX_W-1:0] cnt_sel,
    output logic [NUM_CH-1:0]   led_out,
    output logic [NUM_CH-1:0]   trig_out,
    output logic                any_led,
    output logic                evt_pulse,
    output logic [CH_IDX_W-1:0] last_ch,
    output logic [CNT_W-1:0]    cnt_out
);

    logic [NUM_CH-1:0]   rise_w;
    logic [CNT_W-1:0]    cnt_w [NUM_CH];
    logic [CNT_W-1:0]    cnt_mux;
    logic [CNT_W-1:0]    cnt_out_q;
    logic                evt_pulse_q;
    logic [CH_IDX_W-1:0] last_ch_q, last_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        packet_event_monitor_evt_stretch_ch #(
            .LED_HOLD    (LED_HOLD),
            .TRIG_HOLD   (TRIG_HOLD),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RETRIG      (RETRIG)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en),
            .evt_i     (evt_in[i]),
            .clr_cnt_i (clr_cnt),
            .led_o     (led_out[i]),
            .trig_o    (trig_out[i]),
            .rise_o    (rise_w[i]),
            .cnt_o     (cnt_w[i])
        );
    end

    // Unpopulated selector values read back as zero.
    always_comb begin
        cnt_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_sel == CH_IDX_W'(i)) cnt_mux = cnt_w[i];
        end
    end

    // Descending scan so the lowest simultaneous index wins.
    always_comb begin
        last_ch_d = last_ch_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rise_w[i]) last_ch_d = CH_IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out_q   <= '0;
            evt_pulse_q <= 1'b0;
            last_ch_q   <= '0;
        end else begin
            cnt_out_q   <= cnt_mux;
            evt_pulse_q <= |rise_w;
            last_ch_q   <= last_ch_d;
        end
    end

    assign any_led   = |led_out;
    assign evt_pulse = evt_pulse_q;
    assign last_ch   = last_ch_q;
    assign cnt_out   = cnt_out_q;

endmodule
